// File: rtl/snn_pkg.sv
// Shared types and encodings for the reward evaluator.
package snn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EVAL  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] REW_POS  = 2'b01;
  localparam logic [1:0] REW_NEG  = 2'b11;
  localparam logic [1:0] REW_ZERO = 2'b00;

endpackage

// File: rtl/reward_cmp.sv
// Division-free reward decision: compares the window sum against target*N
// with a tolerance band of TOL*N.
module reward_cmp
  import snn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int TOL    = 2
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] target,
  input  logic [4:0]        n,
  output logic [1:0]        reward
);

  // Wide enough that target*16 + TOL*16 never wraps.
  localparam int CW = ACC_W + DATA_W + 6;

  logic [CW-1:0] t_full;
  logic [CW-1:0] b_full;
  logic [CW-1:0] lo;
  logic [CW-1:0] hi;
  logic [CW-1:0] acc_x;

  always_comb begin
    t_full = CW'(target) * CW'(n);
    b_full = CW'(TOL) * CW'(n);
    lo     = (t_full > b_full) ? (t_full - b_full) : '0;
    hi     = t_full + b_full;
    acc_x  = CW'(acc);
    if (acc == '0) begin
      reward = REW_ZERO;
    end else if ((acc_x >= lo) && (acc_x <= hi)) begin
      reward = REW_POS;
    end else begin
      reward = REW_NEG;
    end
  end

endmodule

// File: rtl/reward_eval.sv
// Windowed reward evaluator: sums N samples, compares the mean against a
// target, and offers a +1/0/-1 reward. Optional streak counter: REWARD_STREAK_EN.
//
// state | meaning
// ACCUM | accepting samples into the window sum
// EVAL  | window complete, reward being computed
// HOLD  | reward offered, waiting for rew_ready
module reward_eval
  import snn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int TOL    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] target,
  input  logic              target_we,
  input  logic [3:0]        win_len,
  output logic              rew_valid,
  input  logic              rew_ready,
  output logic [1:0]        reward,
  output logic [ACC_W-1:0]  acc_out,
  output logic [3:0]        streak
);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        n_q, n_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [1:0]        reward_q, reward_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic              rew_valid_q, rew_valid_d;

  logic       accept;
  logic       first;
  logic [4:0] n_new;
  logic [1:0] cmp_reward;

  reward_cmp #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .TOL    (TOL)
  ) u_cmp (
    .acc    (acc_q),
    .target (tgt_q),
    .n      (n_q),
    .reward (cmp_reward)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    tgt_d       = tgt_q;
    shadow_d    = shadow_q;
    reward_d    = reward_q;
    acc_out_d   = acc_out_q;
    rew_valid_d = rew_valid_q;

    in_ready = rst_n & ena & (state_q == ACCUM);
    accept   = in_valid & in_ready;
    first    = (cnt_q == 5'd0);
    n_new    = (win_len == 4'd0) ? 5'd16 : {1'b0, win_len};

    if (ena) begin
      if (target_we) begin
        shadow_d = target;
      end
      case (state_q)
        ACCUM: begin
          if (accept) begin
            // Window parameters latch on the first sample; a same-cycle write wins.
            if (first) begin
              tgt_d = target_we ? target : shadow_q;
              n_d   = n_new;
            end
            acc_d = acc_q + ACC_W'(in_data);
            cnt_d = cnt_q + 5'd1;
            if (cnt_d == (first ? n_new : n_q)) begin
              state_d = EVAL;
            end
          end
        end
        EVAL: begin
          reward_d    = cmp_reward;
          acc_out_d   = acc_q;
          rew_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: begin
          if (rew_ready) begin
            acc_d       = '0;
            cnt_d       = 5'd0;
            rew_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= 5'd0;
      n_q         <= 5'd16;
      tgt_q       <= '0;
      shadow_q    <= '0;
      reward_q    <= REW_ZERO;
      acc_out_q   <= '0;
      rew_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      tgt_q       <= tgt_d;
      shadow_q    <= shadow_d;
      reward_q    <= reward_d;
      acc_out_q   <= acc_out_d;
      rew_valid_q <= rew_valid_d;
    end
  end

  assign rew_valid = rew_valid_q;
  assign reward    = reward_q;
  assign acc_out   = acc_out_q;

`ifdef REWARD_STREAK_EN
  logic [3:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (ena && (state_q == HOLD) && rew_ready) begin
      if (reward_q == REW_POS) begin
        streak_d = (streak_q == 4'd15) ? streak_q : streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak = streak_q;
`else
  assign streak = 4'd0;
`endif

endmodule

// File: tb/tb_reward_eval.sv
// Self-checking bench for reward_eval: window-level reference model plus
// directed windows with hand-computed rewards and sums.
module tb_reward_eval;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 12;
  localparam int TOL    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] target = '0;
  logic              target_we = 1'b0;
  logic [3:0]        win_len = 4'd4;
  logic              rew_valid;
  logic              rew_ready = 1'b0;
  logic [1:0]        reward;
  logic [ACC_W-1:0]  acc_out;
  logic [3:0]        streak;

  int tests = 0;
  int fails = 0;

  reward_eval #(.DATA_W(DATA_W), .ACC_W(ACC_W), .TOL(TOL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .target    (target),
    .target_we (target_we),
    .win_len   (win_len),
    .rew_valid (rew_valid),
    .rew_ready (rew_ready),
    .reward    (reward),
    .acc_out   (acc_out),
    .streak    (streak)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 collecting, 1 evaluating, 2 offering reward.
  int         m_phase = 0;
  int         m_sum = 0;
  int         m_cnt = 0;
  int         m_n = 16;
  int         m_tgt = 0;
  int         m_shadow = 0;
  logic       m_valid = 1'b0;
  logic [1:0] m_rew = 2'b00;
  logic [11:0] m_accout = '0;
  logic [3:0] m_streak = '0;

  function automatic logic [1:0] model_reward(int sum, int tgt, int n);
    int lo;
    int hi;
    lo = tgt * n - TOL * n;
    if (lo < 0) lo = 0;
    hi = tgt * n + TOL * n;
    if (sum == 0) return 2'b00;
    if (sum >= lo && sum <= hi) return 2'b01;
    return 2'b11;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_sum = 0; m_cnt = 0; m_n = 16; m_tgt = 0; m_shadow = 0;
      m_valid = 1'b0; m_rew = 2'b00; m_accout = '0; m_streak = '0;
    end else if (ena) begin
      if (m_phase == 0) begin
        if (in_valid) begin
          if (m_cnt == 0) begin
            m_tgt = target_we ? int'(target) : m_shadow;
            m_n   = (win_len == 0) ? 16 : int'(win_len);
          end
          m_sum = m_sum + int'(in_data);
          m_cnt = m_cnt + 1;
          if (m_cnt == m_n) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_rew    = model_reward(m_sum, m_tgt, m_n);
        m_accout = m_sum[11:0];
        m_valid  = 1'b1;
        m_phase  = 2;
      end else begin
        if (rew_ready) begin
`ifdef REWARD_STREAK_EN
          if (m_rew == 2'b01) m_streak = (m_streak == 4'd15) ? 4'd15 : m_streak + 4'd1;
          else m_streak = 4'd0;
`endif
          m_sum = 0; m_cnt = 0; m_valid = 1'b0; m_phase = 0;
        end
      end
      if (target_we) m_shadow = int'(target);
    end
  end

  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = rst_n && ena && (m_phase == 0);
    tests++;
    if (in_ready !== exp_ready || rew_valid !== m_valid || reward !== m_rew ||
        acc_out !== m_accout || streak !== m_streak) begin
      fails++;
      $display("FAIL model_cmp t=%0t in_ready=%b/%b rew_valid=%b/%b reward=%b/%b acc_out=%0d/%0d streak=%0d/%0d (actual/required)",
               $time, in_ready, exp_ready, rew_valid, m_valid, reward, m_rew, acc_out, m_accout, streak, m_streak);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_target(input int v);
    target = v[7:0];
    target_we = 1'b1;
    step();
    target_we = 1'b0;
  endtask

  int smp[16];

  task automatic fill4(input int a, input int b, input int c, input int d);
    smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
  endtask

  task automatic drive_samples(input int from, input int to, input int mid_tgt);
    for (int i = from; i < to; i++) begin
      in_valid = 1'b1;
      in_data  = smp[i][7:0];
      if (mid_tgt >= 0 && i == 1) begin
        target = mid_tgt[7:0];
        target_we = 1'b1;
      end
      step();
      target_we = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  // Counts edges after the final accept until rew_valid shows (expect 1).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (rew_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
  endtask

  task automatic run_window(input string name, input int n, input int wl, input int mid_tgt,
                            input int exp_rew, input int exp_acc, input int hold_cycles);
    int lat;
    win_len = wl[3:0];
    drive_samples(0, n, mid_tgt);
    wait_valid(lat);
    check({name, "_lat"}, lat, 1);
    check({name, "_reward"}, int'(reward), exp_rew);
    check({name, "_acc"}, int'(acc_out), exp_acc);
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      step();
      in_valid = 1'b0;
      check({name, "_hold_ready"}, int'(in_ready), 0);
      check({name, "_hold_reward"}, int'(reward), exp_rew);
    end
    rew_ready = 1'b1;
    step();
    rew_ready = 1'b0;
    check({name, "_ack_valid"}, int'(rew_valid), 0);
    check({name, "_ack_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    #20;
    check("rst_ready", int'(in_ready), 0);
    check("rst_valid", int'(rew_valid), 0);
    check("rst_acc_out", int'(acc_out), 0);
    #3 rst_n = 1'b1;
    step();

    write_target(10);
    fill4(10, 10, 10, 10);  run_window("w_match", 4, 4, -1, 1, 40, 5);
    fill4(20, 20, 20, 20);  run_window("w_high", 4, 4, -1, 3, 80, 0);
    fill4(0, 0, 0, 0);      run_window("w_zero", 4, 4, -1, 0, 0, 0);
    fill4(12, 12, 12, 12);  run_window("w_top_edge", 4, 4, -1, 1, 48, 0);
    fill4(13, 12, 12, 12);  run_window("w_above", 4, 4, -1, 3, 49, 0);
    fill4(8, 8, 8, 8);      run_window("w_low_edge", 4, 4, -1, 1, 32, 0);
    fill4(7, 8, 8, 8);      run_window("w_below", 4, 4, -1, 3, 31, 0);

    fill4(10, 10, 10, 10);  run_window("w_mid_we", 4, 4, 50, 1, 40, 0);
    fill4(50, 50, 50, 50);  run_window("w_new_tgt", 4, 4, -1, 1, 200, 0);

    write_target(255);
    for (int i = 0; i < 16; i++) smp[i] = 255;
    run_window("w_len16", 16, 0, -1, 1, 4080, 0);

    // Enable gating mid-window and during the reward handshake.
    write_target(10);
    win_len = 4'd4;
    fill4(10, 10, 10, 10);
    drive_samples(0, 2, -1);
    ena = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd77;
    repeat (3) step();
    check("ena_low_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    ena = 1'b1;
    drive_samples(2, 4, -1);
    wait_valid(lat);
    check("ena_lat", lat, 1);
    ena = 1'b0;
    rew_ready = 1'b1;
    repeat (2) step();
    check("ena_low_hold", int'(rew_valid), 1);
    check("ena_acc", int'(acc_out), 40);
    ena = 1'b1;
    step();
    rew_ready = 1'b0;
    check("ena_ack", int'(rew_valid), 0);

    // Reset mid-window: only post-reset samples count, shadow target is 0.
    fill4(10, 10, 10, 10);
    drive_samples(0, 2, -1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", int'(rew_valid), 0);
    check("rst_mid_ready", int'(in_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    fill4(1, 1, 1, 1);      run_window("w_post_rst", 4, 4, -1, 1, 4, 0);

    // Reset while a reward is pending drops it.
    fill4(3, 3, 3, 3);
    drive_samples(0, 4, -1);
    wait_valid(lat);
    check("hold_rst_reward", int'(reward), 3);
    rst_n = 1'b0;
    #1;
    check("hold_rst_valid", int'(rew_valid), 0);
    check("hold_rst_reward0", int'(reward), 0);
    step();
    rst_n = 1'b1;
    step();

    write_target(10);
    for (int w = 0; w < 17; w++) begin
      fill4(10, 10, 10, 10);
      run_window("w_streak", 4, 4, -1, 1, 40, 0);
    end
`ifdef REWARD_STREAK_EN
    check("streak_sat", int'(streak), 15);
`else
    check("streak_off", int'(streak), 0);
`endif
    fill4(20, 20, 20, 20);  run_window("w_streak_neg", 4, 4, -1, 3, 80, 0);
    check("streak_clear", int'(streak), 0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reward_eval.md
REWARD_EVAL -- requirements
Module: reward_eval

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the neuron output sample and target.
REQ-002 SHALL have parameter ACC_W, default 12, accumulator width, sized for 16 samples of 255.
REQ-003 SHALL have parameter TOL, default 2, per-sample tolerance band around the target.
REQ-004 SHALL have port clk, input, 1, the single clock for all state.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1, enable; when low, all state and outputs hold.
REQ-007 SHALL have port in_data, input, DATA_W, neuron-stage output sample (uo_out of the upstream stage).
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the sample handshake.
REQ-009 SHALL have ports target (input, DATA_W) and target_we (input, 1), the desired mean-output write port.
REQ-010 SHALL have port win_len, input, 4, samples per window; value 0 means 16.
REQ-011 SHALL have ports rew_valid (output, 1) and rew_ready (input, 1), the reward handshake.
REQ-012 SHALL have port reward, output, 2, two's-complement reward: 01 = +1, 11 = -1, 00 = 0.
REQ-013 SHALL have port acc_out, output, ACC_W, the window sum that was evaluated.
REQ-014 SHALL have port streak, output, 4, count of consecutive +1 rewards.

Function
REQ-015 SHALL implement FSM states ACCUM, EVAL and HOLD.
REQ-016 In ACCUM, in_ready SHALL equal ena; a sample SHALL be accepted when in_valid, in_ready and ena are all high.
REQ-017 Each accepted sample SHALL be zero-extended and added to acc; acc SHALL NOT overflow at the ACC_W default.
REQ-018 The accept that makes cnt equal N SHALL move the FSM to EVAL on the next edge.
REQ-019 In EVAL, in_ready SHALL be 0, and the FSM SHALL move to HOLD after 1 cycle.
REQ-020 Entering HOLD SHALL register reward and acc_out and SHALL raise rew_valid, which is high from cycle k+2 after the final accept at cycle k.
REQ-021 Reward SHALL be computed with no division:
  - T = target*N, B = TOL*N;
  - acc == 0 -> 0;
  - else T-B <= acc <= T+B (saturate T-B at 0) -> +1;
  - else -1.
REQ-022 In HOLD, rew_valid, reward and acc_out SHALL stay stable until rew_ready; on handshake the block SHALL clear acc and cnt and return to ACCUM.
REQ-023 in_ready SHALL be 0 in HOLD; there SHALL be no overlap between windows.
REQ-024 target_we SHALL write a shadow register.
REQ-025 Active target and N SHALL be loaded from the shadow and win_len only on the first accept of a window.
REQ-026 If target_we coincides with the first accept, the new target SHALL be used for that window.
REQ-027 When ena is low, no state SHALL change, including handshakes.

Reset
REQ-028 Reset SHALL set, asynchronously:
  - state = ACCUM;
  - acc, cnt, acc_out and streak = 0;
  - reward = 00, rew_valid = 0;
  - shadow and active target = 0, N = 16.
REQ-029 Reset asserted mid-window or in HOLD SHALL discard the partial window and any pending reward.
REQ-030 in_ready SHALL be 0 while rst_n is low.

Configuration
REQ-031 With REWARD_STREAK_EN defined, streak SHALL increment (saturating at 15) on each +1 reward handshake and clear on 0 or -1.
REQ-032 Without REWARD_STREAK_EN, streak SHALL be constant 0 and the counter SHALL NOT be synthesized.

Structure
REQ-033 Package snn_pkg SHALL hold:
  - the FSM state enum;
  - reward encodings REW_POS, REW_NEG and REW_ZERO;
  - DATA_W and ACC_W defaults.
REQ-034 A combinational sub-module reward_cmp SHALL take acc, target, N and TOL and return the 2-bit reward.

Verification
REQ-035 win_len=4, target=10, samples 10,10,10,10 -> rew_valid at k+2, reward=+1, acc_out=40.
REQ-036 win_len=4, target=10, samples 20,20,20,20 (acc=80 > 48) -> reward=-1; four zero samples -> reward=0.
REQ-037 rew_ready held low for 5 cycles -> reward stable, in_ready=0, extra in_valid pulses ignored; rew_ready=1 -> ACCUM, acc=0.
REQ-038 target_we=1, target=50 mid-window -> current window still uses the old target; the next window uses 50.
REQ-039 rst_n low after 2 of 4 samples -> acc=0, rew_valid=0 immediately; the next window evaluates only post-reset samples.
REQ-040 With REWARD_STREAK_EN, 17 consecutive +1 windows -> streak=15; then one -1 -> streak=0.
